top_ioed_tdc: RTL and testbench



---
 rtl/top_ioed_tdc.sv | 236 +++++++++++++++++++++++
 tb/tb_top_ioed_tdc.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/top_ioed_tdc.sv
// top_ioed_tdc: chip-level I/O top for the TOF core (start-triggered window counter + SPI register slave).
// Optional macro TOF_AUTOCLR_EN: a complete 24-bit TOF-read SPI frame also clears INT0 when SPI_CS rises.
module top_ioed_tdc #(
  parameter int          NREG    = 16,
  parameter logic [15:0] WIN_RST = 16'h0020
) (
  input  logic clk_osc,
  input  logic rst_n,
  input  logic TDC_START,
  input  logic SPI_CS,
  input  logic SPI_CLK,
  input  logic SPI_MOSI,
  output logic SPI_MISO,
  output logic INT0,
  output logic INT1
);
  localparam int         AW     = $clog2(NREG);
  localparam logic [7:0] CMD_WR = 8'hA2;
  localparam logic [7:0] CMD_RD = 8'hA3;

  typedef enum logic {ST_IDLE, ST_BUSY} state_e;

  logic [7:0]  regs_q [NREG];
  state_e      state_q;
  logic [15:0] cnt_q;
  logic [7:0]  seq_q;
  logic [23:0] tof_q;
  logic        int0_q, int1_q;

  // Start pulses can be narrower than a clk_osc period, so the edge sets a flop that clk_osc clears.
  logic       startCap_q, startClr_q;
  logic [2:0] startSync_q;
  logic       startDet;

  always_ff @(posedge TDC_START or posedge startClr_q or negedge rst_n) begin
    if (!rst_n)          startCap_q <= 1'b0;
    else if (startClr_q) startCap_q <= 1'b0;
    else                 startCap_q <= 1'b1;
  end

  always_ff @(posedge clk_osc or negedge rst_n) begin
    if (!rst_n) begin
      startSync_q <= 3'b000;
      startClr_q  <= 1'b0;
    end else begin
      startSync_q <= {startSync_q[1:0], startCap_q};
      startClr_q  <= startSync_q[1];
    end
  end

  assign startDet = startSync_q[1] & ~startSync_q[2];

  // SPI receive side: cleared whenever the chip select is idle.
  logic [4:0]  rxCnt_q;
  logic [22:0] rxSh_q;
  logic [7:0]  frameCmd;

  always_ff @(posedge SPI_CLK or posedge SPI_CS) begin
    if (SPI_CS) begin
      rxCnt_q <= 5'd0;
      rxSh_q  <= '0;
    end else if (rxCnt_q != 5'd24) begin
      rxSh_q  <= {rxSh_q[21:0], SPI_MOSI};
      rxCnt_q <= rxCnt_q + 5'd1;
    end
  end

  assign frameCmd = rxSh_q[22:15];

  // Complete frames are announced to clk_osc by toggles; the hold registers stay put until the next frame.
  logic [7:0] holdAddr_q, holdData_q;
  logic       wrTog_q;
`ifdef TOF_AUTOCLR_EN
  logic       tofTog_q;
`endif

  always_ff @(posedge SPI_CLK or negedge rst_n) begin
    if (!rst_n) begin
      holdAddr_q <= 8'h00;
      holdData_q <= 8'h00;
      wrTog_q    <= 1'b0;
`ifdef TOF_AUTOCLR_EN
      tofTog_q   <= 1'b0;
`endif
    end else if (!SPI_CS && rxCnt_q == 5'd23) begin
      if (frameCmd == CMD_WR) begin
        holdAddr_q <= rxSh_q[14:7];
        holdData_q <= {rxSh_q[6:0], SPI_MOSI};
        wrTog_q    <= ~wrTog_q;
      end
`ifdef TOF_AUTOCLR_EN
      if (frameCmd != CMD_WR && frameCmd != CMD_RD) tofTog_q <= ~tofTog_q;
`endif
    end
  end

  // Register read mux, sampled from the SPI side while the value is quasi-static.
  logic [7:0] rdAddr, rdVal;
  assign rdAddr = rxSh_q[7:0];

  always_comb begin
    rdVal = 8'h00;
    if (int'(rdAddr) < NREG) begin
      if (rdAddr == 8'h03) rdVal = {5'b0, int1_q, int0_q, state_q == ST_BUSY};
      else                 rdVal = regs_q[rdAddr[AW-1:0]];
    end
  end

  // SPI transmit side: TOF snapshot taken at SPI_CS fall, register byte swapped in before bit 16.
  logic [23:0] tofSnap_q;
  logic [4:0]  txCnt_q, txIdx;
  logic        rdSel_q;
  logic [7:0]  rdByte_q;

  always_ff @(negedge SPI_CS or negedge rst_n) begin
    if (!rst_n) tofSnap_q <= '0;
    else        tofSnap_q <= tof_q;
  end

  always_ff @(negedge SPI_CLK or posedge SPI_CS) begin
    if (SPI_CS) begin
      txCnt_q  <= 5'd0;
      rdSel_q  <= 1'b0;
      rdByte_q <= 8'h00;
    end else begin
      if (txCnt_q != 5'd24) txCnt_q <= txCnt_q + 5'd1;
      if (txCnt_q == 5'd15 && rxSh_q[15:8] == CMD_RD) begin
        rdSel_q  <= 1'b1;
        rdByte_q <= rdVal;
      end
    end
  end

  assign txIdx = 5'd23 - txCnt_q;

  always_comb begin
    SPI_MISO = 1'b0;
    if (!SPI_CS && txCnt_q != 5'd24) begin
      if (rdSel_q) SPI_MISO = rdByte_q[txIdx[2:0]];
      else         SPI_MISO = tofSnap_q[txIdx];
    end
  end

  // clk_osc side of the frame handshake; commits only once chip select is seen high.
  logic [1:0] csSync_q, wrSync_q;
  logic       wrSeen_q, wrCommit, int1Clr, int0Clr;

  always_ff @(posedge clk_osc or negedge rst_n) begin
    if (!rst_n) begin
      csSync_q <= 2'b11;
      wrSync_q <= 2'b00;
      wrSeen_q <= 1'b0;
    end else begin
      csSync_q <= {csSync_q[0], SPI_CS};
      wrSync_q <= {wrSync_q[0], wrTog_q};
      if (wrCommit) wrSeen_q <= wrSync_q[1];
    end
  end

  assign wrCommit = csSync_q[1] && (wrSync_q[1] != wrSeen_q);
  assign int1Clr  = wrCommit && holdAddr_q == 8'h00 && holdData_q[1];

`ifdef TOF_AUTOCLR_EN
  logic [1:0] tofSync_q;
  logic       tofSeen_q;

  always_ff @(posedge clk_osc or negedge rst_n) begin
    if (!rst_n) begin
      tofSync_q <= 2'b00;
      tofSeen_q <= 1'b0;
    end else begin
      tofSync_q <= {tofSync_q[0], tofTog_q};
      if (int0Clr) tofSeen_q <= tofSync_q[1];
    end
  end

  assign int0Clr = csSync_q[1] && (tofSync_q[1] != tofSeen_q);
`else
  assign int0Clr = 1'b0;
`endif

  // CTRL keeps only the enable bit; its clear bit and STATUS have no storage.
  always_ff @(posedge clk_osc or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= 8'h00;
      regs_q[0] <= 8'h01;
      regs_q[1] <= WIN_RST[7:0];
      regs_q[2] <= WIN_RST[15:8];
    end else if (wrCommit && int'(holdAddr_q) < NREG) begin
      if (holdAddr_q == 8'h00)      regs_q[0] <= {7'b0, holdData_q[0]};
      else if (holdAddr_q != 8'h03) regs_q[holdAddr_q[AW-1:0]] <= holdData_q;
    end
  end

  logic [15:0] winEff;
  assign winEff = ({regs_q[2], regs_q[1]} == 16'd0) ? 16'd1 : {regs_q[2], regs_q[1]};

  // Interrupt sets are written after the clears so a coincident set wins.
  always_ff @(posedge clk_osc or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 16'd0;
      seq_q   <= 8'd0;
      tof_q   <= 24'd0;
      int0_q  <= 1'b0;
      int1_q  <= 1'b0;
    end else begin
      if (int1Clr) int1_q <= 1'b0;
      if (int0Clr) int0_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (startDet && regs_q[0][0]) begin
            state_q <= ST_BUSY;
            cnt_q   <= 16'd0;
            int0_q  <= 1'b0;
          end
        end
        ST_BUSY: begin
          if (startDet) int1_q <= 1'b1;
          if (cnt_q == winEff) begin
            tof_q   <= {seq_q + 8'd1, cnt_q};
            seq_q   <= seq_q + 8'd1;
            int0_q  <= 1'b1;
            state_q <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign INT0 = int0_q;
  assign INT1 = int1_q;
endmodule

// File: tb/tb_top_ioed_tdc.sv
// tb_top_ioed_tdc: directed SPI and TDC vectors with hand-computed expectations for top_ioed_tdc.
// Build-dependent INT0 expectations follow TOF_AUTOCLR_EN.
module tb_top_ioed_tdc;
  logic clk_osc = 1'b0;
  logic rst_n = 1'b0;
  logic TDC_START = 1'b0;
  logic SPI_CS = 1'b1;
  logic SPI_CLK = 1'b0;
  logic SPI_MOSI = 1'b0;
  logic SPI_MISO, INT0, INT1;

  int nChecks = 0;
  int nPassed = 0;
  logic [23:0] rx;
  int cycles;
  logic expInt0AfterTof;

  top_ioed_tdc dut (
    .clk_osc(clk_osc), .rst_n(rst_n), .TDC_START(TDC_START),
    .SPI_CS(SPI_CS), .SPI_CLK(SPI_CLK), .SPI_MOSI(SPI_MOSI),
    .SPI_MISO(SPI_MISO), .INT0(INT0), .INT1(INT1)
  );

  always #20 clk_osc = ~clk_osc;

  task automatic checkOutput(input string tag, input logic [23:0] act, input logic [23:0] exp);
    nChecks++;
    if (act === exp) nPassed++;
    else $display("[TB] FAIL %s: got %06h, expected %06h", tag, act, exp);
  endtask

  // One SPI frame of nbits (frame bits shifted MSB first); MISO sampled just before each rising edge.
  task automatic applyStimulus(input logic [23:0] frame, input int nbits, output logic [23:0] rxd);
    rxd = 24'h0;
    SPI_CS = 1'b0;
    #40;
    for (int i = 0; i < nbits; i++) begin
      SPI_MOSI = frame[23-i];
      #20 rxd[23-i] = SPI_MISO;
      SPI_CLK = 1'b1;
      #40 SPI_CLK = 1'b0;
      #20;
    end
    #20 SPI_CS = 1'b1;
    SPI_MOSI = 1'b0;
    repeat (6) @(negedge clk_osc);
  endtask

  task automatic regWrite(input logic [7:0] addr, input logic [7:0] data);
    logic [23:0] dummy;
    applyStimulus({8'hA2, addr, data}, 24, dummy);
  endtask

  task automatic tdcPulse();
    @(negedge clk_osc);
    #1 TDC_START = 1'b1;
    #5 TDC_START = 1'b0;
  endtask

  task automatic waitInt0(input int budget, inout int cnt);
    while (!INT0 && cnt < budget) begin
      @(negedge clk_osc);
      cnt++;
    end
  endtask

  // Full measurement: INT0 must drop once the start is accepted, then rise about win+4 cycles after the pulse.
  task automatic runMeasure(input int win, input string tag);
    int c;
    c = 0;
    tdcPulse();
    repeat (4) begin
      @(negedge clk_osc);
      c++;
    end
    checkOutput({tag, "_int0Drop"}, {23'd0, INT0}, 24'd0);
    waitInt0(win + 40, c);
    checkOutput({tag, "_latencyOk"}, {23'd0, (c >= win + 3 && c <= win + 5)}, 24'd1);
  endtask

  initial begin
`ifdef TOF_AUTOCLR_EN
    expInt0AfterTof = 1'b0;
`else
    expInt0AfterTof = 1'b1;
`endif
    repeat (3) @(negedge clk_osc);
    checkOutput("rstInt0", {23'd0, INT0}, 24'd0);
    checkOutput("rstInt1", {23'd0, INT1}, 24'd0);
    checkOutput("rstMiso", {23'd0, SPI_MISO}, 24'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk_osc);

    applyStimulus(24'hA30000, 24, rx); checkOutput("rdCtrl", rx, 24'h000001);
    applyStimulus(24'hA30100, 24, rx); checkOutput("rdWinL", rx, 24'h000020);
    applyStimulus(24'hA30200, 24, rx); checkOutput("rdWinH", rx, 24'h000000);

    regWrite(8'h06, 8'hAB);
    applyStimulus(24'hA30600, 24, rx); checkOutput("scratch06", rx[7:0], 24'hAB);
    regWrite(8'h03, 8'hFF);
    applyStimulus(24'hA30300, 24, rx); checkOutput("statusWrIgnored", rx[7:0], 24'h00);
    regWrite(8'h20, 8'h11);
    applyStimulus(24'hA32000, 24, rx); checkOutput("outOfRange", rx[7:0], 24'h00);

    applyStimulus(24'hA20755, 16, rx);
    applyStimulus(24'hA30700, 24, rx); checkOutput("abortNoWrite", rx[7:0], 24'h00);

    runMeasure(32'h20, "meas1");
    applyStimulus(24'hA30300, 24, rx); checkOutput("status1", rx, 24'h010002);
    applyStimulus(24'h000000, 24, rx); checkOutput("tof1", rx, 24'h010020);
    checkOutput("int0AfterTofRead", {23'd0, INT0}, {23'd0, expInt0AfterTof});

    regWrite(8'h01, 8'h05);
    regWrite(8'h02, 8'h00);
    runMeasure(5, "meas2");
    applyStimulus(24'h550000, 24, rx); checkOutput("tof2", rx, 24'h020005);

    regWrite(8'h01, 8'hC8);
    tdcPulse();
    repeat (12) @(negedge clk_osc);
    tdcPulse();
    repeat (8) @(negedge clk_osc);
    checkOutput("overrunInt1", {23'd0, INT1}, 24'd1);
    applyStimulus(24'hA30300, 24, rx); checkOutput("statusBusy", rx[7:0], 24'h05);
    cycles = 0;
    waitInt0(400, cycles);
    checkOutput("meas3Done", {23'd0, INT0}, 24'd1);
    applyStimulus(24'hA30300, 24, rx); checkOutput("statusDone", rx[7:0], 24'h06);
    applyStimulus(24'h000000, 24, rx); checkOutput("tof3", rx, 24'h0300C8);
    regWrite(8'h00, 8'h03);
    checkOutput("int1Cleared", {23'd0, INT1}, 24'd0);
    applyStimulus(24'hA30000, 24, rx); checkOutput("ctrlReadback", rx[7:0], 24'h01);

    regWrite(8'h00, 8'h00);
    tdcPulse();
    repeat (50) @(negedge clk_osc);
    checkOutput("disabledInt0", {23'd0, INT0}, {23'd0, expInt0AfterTof});
    applyStimulus(24'hA30300, 24, rx);
    checkOutput("disabledStatus", rx[7:0], {22'd0, expInt0AfterTof, 1'b0});
    regWrite(8'h00, 8'h01);

    tdcPulse();
    repeat (10) @(negedge clk_osc);
    rst_n = 1'b0;
    #30;
    @(negedge clk_osc);
    rst_n = 1'b1;
    repeat (3) @(negedge clk_osc);
    checkOutput("midRstInt0", {23'd0, INT0}, 24'd0);
    applyStimulus(24'hA30100, 24, rx); checkOutput("midRstWinL", rx, 24'h000020);
    runMeasure(32'h20, "meas4");
    applyStimulus(24'h000000, 24, rx); checkOutput("tofAfterRst", rx, 24'h010020);

    $display("%0d/%0d checks passed", nPassed, nChecks);
    $finish;
  end
endmodule
